// File: rtl/disk_ctrl.sv
// Block-transfer disk controller: 128x32 buffer moved to/from word-addressed storage.
// Optional XOR checksum of transferred words enabled by DISK_CTRL_CHECKSUM_EN.
module disk_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        read_pause,
  input  logic        write_pause,
  input  logic [8:0]  disk_addr,
  input  logic [31:0] disk_data_out,
  output logic [31:0] disk_data_in,
  output logic        disk_operate_done,
  output logic        busy,
  output logic        st_req,
  output logic        st_we,
  output logic [31:0] st_addr,
  output logic [31:0] st_wdata,
  input  logic [31:0] st_rdata,
  input  logic        st_ack,
  output logic [31:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_REQ   = 3'd1,
    S_WR_FETCH = 3'd2,
    S_WR_REQ   = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_buf [0:127];
  logic [24:0] r_block;
  logic [6:0]  r_idx;
  logic [31:0] r_st_wdata;
  logic [31:0] r_data_in;
  logic        r_st_req;
  logic        r_st_we;
  logic        r_busy;
  logic        r_done;
  logic        w_start;
  logic        w_bus_wr;
  logic        w_rd_ack;
  logic        w_wr_ack;
  logic        w_last;
  logic        w_unused;

  // Block bits above 24 never reach the storage address.
  assign w_unused = ^instruction[28:25];

  assign w_start  = (r_state == S_IDLE) && (read_pause || write_pause);
  assign w_bus_wr = instruction[31] && instruction[30] && !instruction[29] && !r_busy;
  assign w_rd_ack = (r_state == S_RD_REQ) && st_ack;
  assign w_wr_ack = (r_state == S_WR_REQ) && st_ack;
  assign w_last   = (r_idx == 7'd127);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (write_pause)     w_next = S_WR_FETCH;
        else if (read_pause) w_next = S_RD_REQ;
        else                 w_next = S_IDLE;
      end
      S_RD_REQ: begin
        if (st_ack && w_last) w_next = S_DONE;
        else                  w_next = S_RD_REQ;
      end
      S_WR_FETCH: w_next = S_WR_REQ;
      S_WR_REQ: begin
        if (st_ack && w_last) w_next = S_DONE;
        else if (st_ack)      w_next = S_WR_FETCH;
        else                  w_next = S_WR_REQ;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_block    <= 25'd0;
      r_idx      <= 7'd0;
      r_st_req   <= 1'b0;
      r_st_we    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_st_wdata <= 32'd0;
      r_data_in  <= 32'd0;
    end else begin
      r_st_req  <= (w_next == S_RD_REQ) || (w_next == S_WR_REQ);
      r_st_we   <= (w_next == S_WR_REQ);
      r_busy    <= (w_next != S_IDLE);
      r_done    <= (w_next == S_DONE);
      r_data_in <= r_buf[disk_addr[8:2]];
      if (w_start) begin
        r_block <= instruction[24:0];
        r_idx   <= 7'd0;
      end else if (w_rd_ack || w_wr_ack) begin
        r_idx <= r_idx + 7'd1;
      end
      if (r_state == S_WR_FETCH) r_st_wdata <= r_buf[r_idx];
    end
  end

  // Buffer survives reset; bus writes are only possible while idle.
  always_ff @(posedge clk) begin
    if (w_rd_ack)      r_buf[r_idx]           <= st_rdata;
    else if (w_bus_wr) r_buf[disk_addr[8:2]]  <= disk_data_out;
  end

`ifdef DISK_CTRL_CHECKSUM_EN
  logic [31:0] r_checksum;

  // XOR of every word accepted by storage during the current transfer.
  always_ff @(posedge clk) begin
    if (rst)           r_checksum <= 32'd0;
    else if (w_start)  r_checksum <= 32'd0;
    else if (w_rd_ack) r_checksum <= r_checksum ^ st_rdata;
    else if (w_wr_ack) r_checksum <= r_checksum ^ r_st_wdata;
  end

  assign checksum = r_checksum;
`else
  assign checksum = 32'd0;
`endif

  assign disk_data_in      = r_data_in;
  assign disk_operate_done = r_done;
  assign busy              = r_busy;
  assign st_req            = r_st_req;
  assign st_we             = r_st_we;
  assign st_addr           = {r_block, r_idx};
  assign st_wdata          = r_st_wdata;

endmodule

// File: doc/disk_ctrl.md
DISK_CTRL -- requirements
Module: disk_ctrl

Interface
REQ-001 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have instruction  input  32  [31] device select, [30] write enable, [29] 1=disk op / 0=buffer access, [28:0] block number.
REQ-004 SHALL have read_pause  input  1  one-cycle pulse: start block read, storage -> buffer.
REQ-005 SHALL have write_pause  input  1  one-cycle pulse: start block write, buffer -> storage.
REQ-006 SHALL have disk_addr  input  9  buffer byte address; word index = disk_addr[8:2].
REQ-007 SHALL have disk_data_out  input  32  bus write data for the buffer.
REQ-008 SHALL have disk_data_in  output  32  buffer read data.
REQ-009 SHALL have disk_operate_done  output  1  one-cycle pulse at block transfer completion.
REQ-010 SHALL have busy  output  1  high while a block transfer is in progress.
REQ-011 SHALL have st_req, st_we  output  1 each  storage request / storage write.
REQ-012 SHALL have st_addr, st_wdata  output  32 each  storage word address / write data.
REQ-013 SHALL have st_rdata  input  32, st_ack  input  1  storage read data / request accepted.
REQ-014 SHALL have checksum  output  32  XOR of words of last transfer (see Configuration).

Function
REQ-015 SHALL hold a 128 x 32 block buffer, one block = 512 bytes.
REQ-016 Bus write: when instruction[31]=1, [30]=1, [29]=0 and busy=0, buffer[disk_addr[8:2]] SHALL take disk_data_out that cycle; writes while busy are dropped.
REQ-017 disk_data_in SHALL equal buffer[disk_addr[8:2]] registered, 1-cycle latency, in any state.
REQ-018 FSM states SHALL be IDLE, RD_REQ, WR_FETCH, WR_REQ, DONE.
REQ-019 IDLE: write_pause -> latch instruction[28:0] as block, idx=0, go WR_FETCH; else read_pause -> same latch, go RD_REQ; both together -> write wins.
REQ-020 Start pulses in any state other than IDLE SHALL be ignored.
REQ-021 RD_REQ: st_req=1, st_we=0; on st_ack buffer[idx] <= st_rdata; idx==127 -> DONE, else idx+1, stay.
REQ-022 WR_FETCH: read buffer[idx] into st_wdata register, go WR_REQ (1 cycle).
REQ-023 WR_REQ: st_req=1, st_we=1; on st_ack idx==127 -> DONE, else idx+1, go WR_FETCH.
REQ-024 st_addr SHALL be {block[24:0], idx[6:0]}; block bits [28:25] ignored.
REQ-025 st_addr, st_we, st_wdata SHALL be stable while st_req=1 and st_ack=0; st_ack with st_req=0 ignored.
REQ-026 DONE: disk_operate_done=1 exactly one cycle, then IDLE.
REQ-027 busy SHALL be 1 in RD_REQ, WR_FETCH, WR_REQ, DONE; 0 in IDLE.
REQ-028 Storage stall of any length SHALL only extend the current state; no timeout.

Reset
REQ-029 rst SHALL force IDLE, idx=0, block=0, st_req=0, st_we=0, st_addr=0, st_wdata=0, disk_operate_done=0, busy=0, checksum=0, disk_data_in=0.
REQ-030 rst mid-transfer SHALL abort without done pulse; buffer contents SHALL NOT be cleared.

Configuration
REQ-031 Macro DISK_CTRL_CHECKSUM_EN defined: checksum cleared at transfer start, XORed with each word on st_ack, final value held from DONE until next start.
REQ-032 Macro undefined: checksum SHALL be constant 0 and no accumulator logic instantiated.

Verification
REQ-033 Read: block=5, read_pause, storage returns word i = 0xA000_0000+i with 2-cycle ack delay -> st_addr 0x280..0x2FF in order, one done pulse, buffer word 127 reads 0xA000_007F.
REQ-034 Write: bus-write 0x1234_5678 at disk_addr 0x1FC, block=1, write_pause -> final request st_addr=0xFF, st_we=1, st_wdata=0x1234_5678, then done.
REQ-035 Bus write while busy: data 0xDEAD_BEEF at addr 0 during read -> buffer[0] = storage word, not 0xDEAD_BEEF.
REQ-036 Simultaneous read_pause+write_pause in IDLE -> write transfer (st_we=1); pulse during transfer -> no second transfer, single done.
REQ-037 rst at idx=40 of read -> st_req=0 next cycle, no done, buffer[0..39] retain read data.
REQ-038 DISK_CTRL_CHECKSUM_EN defined, read of words all 0x0000_0001 -> checksum=0 (128 words); with word 0 = 0xFF, rest 0 -> checksum=0xFF.
